ex_operand_muldiv: RTL and testbench
====================================

Name: ex_operand_muldiv

Overview:
- Next-generation execute-stage front end for the five-stage pipeline.
- Generalises operand forwarding to XLEN-wide data and FWD_SRCS forwarding sources.
- Adds an iterative multiply/divide unit with architectural HI/LO registers, a pipeline stall output and a flush input.
- Sits between ID/EX and the existing ALU. Drives the ALU operands, the store data and the MFHI/MFLO result.

Parameters:
- XLEN, 32, datapath width.
- FWD_SRCS, 2, number of forwarding sources. 1 = EX/MEM, 2 = MEM/WB, and so on.
- MUL_LAT, 4, multiply latency in cycles (≥1).
- SHW, $clog2(XLEN), shift-amount width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  an instruction occupies EX this cycle.
- flush  in  1  kill the in-flight multiply/divide.
- reg_a  in  XLEN  rs value from ID/EX.
- reg_b  in  XLEN  rt value from ID/EX.
- fwd_data  in  FWD_SRCS*XLEN  forwarding sources, packed; source k is bits [k*XLEN +: XLEN].
- fwd_sel_a  in  $clog2(FWD_SRCS+1)  0 = reg_a; k = source k-1.
- fwd_sel_b  in  $clog2(FWD_SRCS+1)  0 = reg_b; k = source k-1.
- alu_src1  in  1  operand A = zero-extended shamt.
- alu_src2  in  1  operand B = imm.
- shamt  in  SHW  shift amount.
- imm  in  XLEN  extended immediate.
- md_op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; any other code = NONE.
- opnd_a  out  XLEN  ALU input 1.
- opnd_b  out  XLEN  ALU input 2.
- store_data  out  XLEN  forwarded rt, ignoring alu_src2.
- md_result  out  XLEN  HI or LO for MFHI/MFLO, else 0.
- md_busy  out  1  multiply/divide in progress.
- stall  out  1  hold IF/ID/EX this cycle.

Behaviour:
- Forwarding (combinational):
  - fa = sel-indexed source; a selector value > FWD_SRCS yields 0. fb likewise.
  - opnd_a = alu_src1 ? zext(shamt) : fa.
  - opnd_b = alu_src2 ? imm : fb.
  - store_data = fb.
- Reset: on the clock edge with reset=1, HI=0, LO=0, md_busy=0, counter=0, any operation is aborted. Reset overrides all other inputs.
- md_class = md_op in {1..8}.
- stall = in_valid & md_busy & md_class, combinational. Any HI/LO-touching instruction waits.
- Accept:
  - Condition: in_valid & !stall & !flush & md_op in 1..4.
  - Latch operands fa/fb, set md_busy=1, load counter.
  - The issuing instruction is not stalled; it retires with no register write.
- FSM: IDLE → MUL (MULT/MULTU) or DIV (DIV/DIVU).
  - MUL holds md_busy for MUL_LAT cycles.
  - DIV holds md_busy for XLEN cycles, restoring radix-2, one quotient bit per cycle. Signed operands are converted to magnitudes at accept and the signs fixed at finish.
  - On the final busy cycle's edge, HI/LO are written and the FSM returns to IDLE; md_busy=0 the next cycle.
  - A back-to-back accept is allowed in that next cycle.
- Results:
  - MULT/MULTU: {HI,LO} = full 2*XLEN product.
  - DIV/DIVU: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Divide by zero: LO = all ones, HI = dividend, normal latency.
  - Signed MIN / -1: LO = MIN, HI = 0.
- MFHI/MFLO: when in_valid & !stall, md_result = HI/LO (combinational from the registers). While stalled, or for any other md_op, md_result = 0.
- Flush: flush while md_busy aborts the operation. The FSM goes to IDLE the next cycle and HI/LO are unchanged. flush in the accept cycle prevents the start.
- Flush and finish in the same cycle: flush wins; HI/LO are not written.
- in_valid=0: no accept, stall=0.

Optional Feature:
- MD_MTHILO_EN defined:
  - MTHI/MTLO (when in_valid & !stall & !flush) write fa into HI/LO at the clock edge, in a single cycle.
  - When MTHI/MTLO and a finishing operation would both write HI/LO, stall applies first, so this cannot occur.
- MD_MTHILO_EN undefined: codes 7 and 8 decode as NONE (no stall, no write).

Test Plan:
- Forwarding (FWD_SRCS=2):
  - reg_a=1, fwd_data={32'hB,32'hA}, fwd_sel_a=2 → opnd_a=0xB.
  - fwd_sel_b=3 → fb=0, so opnd_b=0 and store_data=0.
  - alu_src1=1, shamt=5 → opnd_a=5.
- Multiply plus stalled move-from: MULT 0xFFFFFFFF × 2, then MFLO the next cycle.
  - stall=1 for the remaining busy cycles (MUL_LAT=4 busy total).
  - Then md_result=0xFFFFFFFE; HI=0xFFFFFFFF.
- Signed divide: DIV −7 / 2 → md_busy for exactly 32 cycles, LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- Divide edge cases:
  - DIVU 9 / 0 → LO=0xFFFFFFFF, HI=9.
  - DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- Flush and reset:
  - Flush at busy cycle 10 of a DIV → md_busy=0 next cycle; HI/LO keep their prior values.
  - Reset mid-MUL → HI=LO=0, md_busy=0.
- MTHI/MTLO with MD_MTHILO_EN: MTHI fa=0x1234, then MFHI → md_result=0x1234.
  - Without the macro: HI unchanged, stall=0.

Source files
------------

// File: rtl/ex_operand_muldiv_if.sv
// Execute-stage operand/mul-div bundle between ID/EX, the ALU and the HI/LO unit.
// master drives instruction fields; slave (ex_operand_muldiv) returns operands and status.
interface ex_operand_muldiv_if #(
  parameter int XLEN     = 32,
  parameter int FWD_SRCS = 2,
  parameter int SHW      = $clog2(XLEN),
  parameter int SELW     = $clog2(FWD_SRCS + 1)
);
  logic                     in_valid;
  logic                     flush;
  logic [XLEN-1:0]          reg_a;
  logic [XLEN-1:0]          reg_b;
  logic [FWD_SRCS*XLEN-1:0] fwd_data;
  logic [SELW-1:0]          fwd_sel_a;
  logic [SELW-1:0]          fwd_sel_b;
  logic                     alu_src1;
  logic                     alu_src2;
  logic [SHW-1:0]           shamt;
  logic [XLEN-1:0]          imm;
  logic [3:0]               md_op;
  logic [XLEN-1:0]          opnd_a;
  logic [XLEN-1:0]          opnd_b;
  logic [XLEN-1:0]          store_data;
  logic [XLEN-1:0]          md_result;
  logic                     md_busy;
  logic                     stall;

  modport master (
    output in_valid, flush, reg_a, reg_b, fwd_data, fwd_sel_a, fwd_sel_b,
           alu_src1, alu_src2, shamt, imm, md_op,
    input  opnd_a, opnd_b, store_data, md_result, md_busy, stall
  );

  modport slave (
    input  in_valid, flush, reg_a, reg_b, fwd_data, fwd_sel_a, fwd_sel_b,
           alu_src1, alu_src2, shamt, imm, md_op,
    output opnd_a, opnd_b, store_data, md_result, md_busy, stall
  );
endinterface

// File: rtl/ex_operand_muldiv.sv
// Execute-stage operand forwarding plus iterative multiply/divide with HI/LO registers.
// Define MD_MTHILO_EN to enable MTHI/MTLO (md_op 7/8); otherwise those codes are NONE.
module ex_operand_muldiv #(
  parameter int XLEN     = 32,
  parameter int FWD_SRCS = 2,
  parameter int MUL_LAT  = 4,
  parameter int SHW      = $clog2(XLEN)
) (
  input logic               clk,
  input logic               reset,
  ex_operand_muldiv_if.slave bus
);
  localparam int SELW   = $clog2(FWD_SRCS + 1);
  localparam int CNTMAX = (MUL_LAT > XLEN) ? MUL_LAT : XLEN;
  localparam int CW     = $clog2(CNTMAX + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  logic [XLEN-1:0] fa, fb;

  always_comb begin
    fa = '0;
    fb = '0;
    if (bus.fwd_sel_a == '0) fa = bus.reg_a;
    if (bus.fwd_sel_b == '0) fb = bus.reg_b;
    for (int k = 0; k < FWD_SRCS; k++) begin
      if (bus.fwd_sel_a == SELW'(k + 1)) fa = bus.fwd_data[k*XLEN +: XLEN];
      if (bus.fwd_sel_b == SELW'(k + 1)) fb = bus.fwd_data[k*XLEN +: XLEN];
    end
  end

  assign bus.opnd_a     = bus.alu_src1 ? XLEN'(bus.shamt) : fa;
  assign bus.opnd_b     = bus.alu_src2 ? bus.imm : fb;
  assign bus.store_data = fb;

  logic is_mul, is_div, is_mfhi, is_mflo, is_mthi, is_mtlo, op_signed, md_class;

  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_mfhi   = 1'b0;
    is_mflo   = 1'b0;
    is_mthi   = 1'b0;
    is_mtlo   = 1'b0;
    op_signed = 1'b0;
    case (bus.md_op)
      4'd1:    begin is_mul = 1'b1; op_signed = 1'b1; end
      4'd2:    is_mul = 1'b1;
      4'd3:    begin is_div = 1'b1; op_signed = 1'b1; end
      4'd4:    is_div = 1'b1;
      4'd5:    is_mfhi = 1'b1;
      4'd6:    is_mflo = 1'b1;
`ifdef MD_MTHILO_EN
      4'd7:    is_mthi = 1'b1;
      4'd8:    is_mtlo = 1'b1;
`endif
      default: ;
    endcase
    md_class = is_mul | is_div | is_mfhi | is_mflo | is_mthi | is_mtlo;
  end

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  // a_q: multiplicand, or dividend/quotient shift register while dividing.
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d;
  logic            sgn_q, sgn_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;

  logic busy, issue, accept;
  assign busy      = (state_q != ST_IDLE);
  assign bus.stall = bus.in_valid & busy & md_class;
  assign issue     = bus.in_valid & ~bus.stall & ~bus.flush;
  assign accept    = issue & (is_mul | is_div);
  assign bus.md_busy = busy;

  assign bus.md_result = (bus.in_valid & ~bus.stall & is_mfhi) ? hi_q :
                         (bus.in_valid & ~bus.stall & is_mflo) ? lo_q : '0;

  logic [2*XLEN-1:0] ext_a, ext_b, prod;
  always_comb begin
    ext_a = sgn_q ? {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
    ext_b = sgn_q ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
    prod  = ext_a * ext_b;
  end

  // Restoring divide step on magnitudes: shift in next dividend bit, trial-subtract.
  logic [XLEN:0]   diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_nx, quo_nx, rem_fix, quo_fix;
  always_comb begin
    diff    = {rem_q, a_q[XLEN-1]} - {1'b0, b_q};
    q_bit   = ~diff[XLEN];
    rem_nx  = q_bit ? diff[XLEN-1:0] : {rem_q[XLEN-2:0], a_q[XLEN-1]};
    quo_nx  = {a_q[XLEN-2:0], q_bit};
    quo_fix = neg_q_q ? -quo_nx : quo_nx;
    rem_fix = neg_r_q ? -rem_nx : rem_nx;
  end

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  always_comb begin
    a_neg = op_signed & fa[XLEN-1];
    b_neg = op_signed & fb[XLEN-1];
    a_mag = a_neg ? -fa : fa;
    b_mag = b_neg ? -fb : fb;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    if (busy) begin
      // Flush beats a same-cycle finish: HI/LO stay untouched.
      if (bus.flush) begin
        state_d = ST_IDLE;
      end else begin
        if (state_q == ST_DIV) begin
          a_d   = quo_nx;
          rem_d = rem_nx;
        end
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (state_q == ST_MUL) begin
            {hi_d, lo_d} = prod;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end else if (accept) begin
      if (is_mul) begin
        state_d = ST_MUL;
        cnt_d   = CW'(MUL_LAT - 1);
        a_d     = fa;
        b_d     = fb;
        sgn_d   = op_signed;
      end else begin
        state_d = ST_DIV;
        cnt_d   = CW'(XLEN - 1);
        a_d     = a_mag;
        b_d     = b_mag;
        rem_d   = '0;
        // Divide by zero keeps the all-ones magnitude quotient un-negated.
        neg_q_d = (a_neg ^ b_neg) & (fb != '0);
        neg_r_d = a_neg;
      end
    end
    if (issue & is_mthi) hi_d = fa;
    if (issue & is_mtlo) lo_d = fa;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
endmodule

// File: tb/tb_ex_operand_muldiv.sv
// Bench for ex_operand_muldiv: directed cases plus random traffic against an arithmetic model.
module tb_ex_operand_muldiv;
  localparam int XLEN = 32, FWD_SRCS = 2, MUL_LAT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_operand_muldiv_if #(.XLEN(XLEN), .FWD_SRCS(FWD_SRCS)) bus ();
  ex_operand_muldiv #(.XLEN(XLEN), .FWD_SRCS(FWD_SRCS), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] r,
                                      input logic [63:0] d);
    if (sel == 2'd0) return r;
    if (int'(sel) <= FWD_SRCS) return d[(int'(sel) - 1)*32 +: 32];
    return 32'd0;
  endfunction

  function automatic bit in_class(input logic [3:0] op);
`ifdef MD_MTHILO_EN
    return op >= 4'd1 && op <= 4'd8;
`else
    return op >= 4'd1 && op <= 4'd6;
`endif
  endfunction

  task automatic md_compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'd0;
    case (op)
      4'd1: p = 64'(sa * sb);
      4'd2: p = {32'd0, a} * {32'd0, b};
      4'd3: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      4'd4: p = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: ;
    endcase
    {hi, lo} = p;
  endtask

  // Model: architectural HI/LO, busy cycles left, and the pending result.
  logic [31:0] m_hi, m_lo, r_hi, r_lo;
  int m_left = 0;
  bit model_ok = 1'b0;

  always @(posedge clk) begin
    logic [31:0] fa, fb;
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0; model_ok = 1'b1;
    end else if (model_ok) begin
      fa = fwd(bus.fwd_sel_a, bus.reg_a, bus.fwd_data);
      fb = fwd(bus.fwd_sel_b, bus.reg_b, bus.fwd_data);
      if (m_left > 0) begin
        if (bus.flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin m_hi = r_hi; m_lo = r_lo; end
        end
      end else if (bus.in_valid && !bus.flush) begin
        if (bus.md_op >= 4'd1 && bus.md_op <= 4'd4) begin
          md_compute(bus.md_op, fa, fb, r_hi, r_lo);
          m_left = (bus.md_op <= 4'd2) ? MUL_LAT : XLEN;
        end
`ifdef MD_MTHILO_EN
        if (bus.md_op == 4'd7) m_hi = fa;
        if (bus.md_op == 4'd8) m_lo = fa;
`endif
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] fa, fb, e_res;
    bit e_stall;
    if (model_ok && !reset) begin
      fa = fwd(bus.fwd_sel_a, bus.reg_a, bus.fwd_data);
      fb = fwd(bus.fwd_sel_b, bus.reg_b, bus.fwd_data);
      e_stall = bus.in_valid && m_left > 0 && in_class(bus.md_op);
      e_res = 32'd0;
      if (bus.in_valid && !e_stall && bus.md_op == 4'd5) e_res = m_hi;
      if (bus.in_valid && !e_stall && bus.md_op == 4'd6) e_res = m_lo;
      chk("opnd_a", bus.opnd_a, bus.alu_src1 ? {27'd0, bus.shamt} : fa);
      chk("opnd_b", bus.opnd_b, bus.alu_src2 ? bus.imm : fb);
      chk("store_data", bus.store_data, fb);
      chk("md_busy", bus.md_busy, m_left > 0);
      chk("stall", bus.stall, e_stall);
      chk("md_result", bus.md_result, e_res);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1; bus.md_op = op; bus.reg_a = a; bus.reg_b = b;
    bus.fwd_sel_a = 2'd0; bus.fwd_sel_b = 2'd0;
    tick();
    bus.in_valid = 1'b0; bus.md_op = 4'd0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && bus.md_busy; i++) tick();
    chk("wait_idle_bound", bus.md_busy, 1'b0);
  endtask

  task automatic rd(input logic [3:0] op, input logic [31:0] exp, input string name);
    bus.in_valid = 1'b1; bus.md_op = op;
    #1;
    chk(name, bus.md_result, exp);
    tick();
    bus.in_valid = 1'b0; bus.md_op = 4'd0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cnt;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.reg_a = '0; bus.reg_b = '0;
    bus.fwd_data = '0; bus.fwd_sel_a = '0; bus.fwd_sel_b = '0; bus.alu_src1 = 1'b0;
    bus.alu_src2 = 1'b0; bus.shamt = '0; bus.imm = '0; bus.md_op = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset_busy", bus.md_busy, 1'b0);
    chk("reset_stall", bus.stall, 1'b0);
    rd(4'd6, 32'd0, "reset_lo");

    // Forwarding
    bus.reg_a = 32'd1; bus.fwd_data = {32'hB, 32'hA}; bus.fwd_sel_a = 2'd2; bus.fwd_sel_b = 2'd3;
    #1;
    chk("fwd_sel_a2", bus.opnd_a, 32'hB);
    chk("fwd_sel_b3_opnd", bus.opnd_b, 32'd0);
    chk("fwd_sel_b3_store", bus.store_data, 32'd0);
    bus.alu_src1 = 1'b1; bus.shamt = 5'd5;
    #1;
    chk("shamt_opnd", bus.opnd_a, 32'd5);
    bus.alu_src1 = 1'b0;
    tick();

    // MULT then stalled MFLO
    issue(4'd1, 32'hFFFF_FFFF, 32'd2);
    bus.in_valid = 1'b1; bus.md_op = 4'd6;
    for (int i = 0; i < MUL_LAT; i++) begin
      #1;
      chk("mflo_stalled", bus.stall, 1'b1);
      tick();
    end
    #1;
    chk("mflo_released", bus.stall, 1'b0);
    chk("mult_lo", bus.md_result, 32'hFFFF_FFFE);
    tick();
    rd(4'd5, 32'hFFFF_FFFF, "mult_hi");

    // Signed divide latency and result
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    cnt = 0;
    while (bus.md_busy && cnt < 100) begin cnt++; tick(); end
    chk("div_busy_cycles", 64'(cnt), 64'd32);
    rd(4'd6, 32'hFFFF_FFFD, "div_lo");
    rd(4'd5, 32'hFFFF_FFFF, "div_hi");

    issue(4'd4, 32'd9, 32'd0);
    wait_idle();
    rd(4'd6, 32'hFFFF_FFFF, "divu0_lo");
    rd(4'd5, 32'd9, "divu0_hi");
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    rd(4'd6, 32'h8000_0000, "divovf_lo");
    rd(4'd5, 32'd0, "divovf_hi");

    // Flush at busy cycle 10
    issue(4'd3, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", bus.md_busy, 1'b0);
    rd(4'd5, 32'd0, "flush_hi");
    rd(4'd6, 32'h8000_0000, "flush_lo");

    // Reset mid-MUL
    issue(4'd1, 32'd3, 32'd5);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_busy", bus.md_busy, 1'b0);
    rd(4'd5, 32'd0, "rst_hi");
    rd(4'd6, 32'd0, "rst_lo");

    // MTHI while busy, then idle
    issue(4'd1, 32'd3, 32'd5);
    bus.in_valid = 1'b1; bus.md_op = 4'd7; bus.reg_a = 32'h1234;
    #1;
`ifdef MD_MTHILO_EN
    chk("mthi_busy_stall", bus.stall, 1'b1);
`else
    chk("mthi_busy_stall", bus.stall, 1'b0);
`endif
    bus.in_valid = 1'b0;
    wait_idle();
    bus.in_valid = 1'b1; bus.md_op = 4'd7; bus.reg_a = 32'h1234;
    tick();
`ifdef MD_MTHILO_EN
    rd(4'd5, 32'h1234, "mthi_hi");
`else
    rd(4'd5, 32'd0, "mthi_hi");
`endif
    rd(4'd6, 32'd15, "mul_lo_after_mthi");

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      bus.in_valid = ($urandom_range(0, 9) < 8);
      bus.flush = ($urandom_range(0, 29) == 0);
      bus.md_op = 4'($urandom_range(0, 10));
      bus.reg_a = pick(); bus.reg_b = pick();
      bus.fwd_data = {pick(), pick()};
      bus.fwd_sel_a = 2'($urandom_range(0, 3)); bus.fwd_sel_b = 2'($urandom_range(0, 3));
      bus.alu_src1 = 1'($urandom); bus.alu_src2 = 1'($urandom);
      bus.shamt = 5'($urandom); bus.imm = $urandom;
      tick();
    end
    reset = 1'b0; bus.in_valid = 1'b0; bus.flush = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
